// File: rtl/mem_access_ctrl.sv
// Memory access controller: CPU byte/halfword/word loads and stores onto a
// single-port registered-read block RAM, sub-word stores as read-modify-write.
// Optional misalignment trap enabled with `define MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [DATA_W-1:0] w_merged;
  logic              w_word_store;
  logic              w_unused_addr;

  // Upper address bits alias onto the RAM word space.
  assign w_unused_addr = ^addr[31:ADDR_W+2];
  assign w_word_store  = we & size[1];

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`endif

  // Big-endian lanes: lane 0 is the most significant byte.
  always_comb begin
    w_byte   = 8'h00;
    w_half   = r_lane[1] ? ram_dout[15:0] : ram_dout[31:16];
    w_load   = ram_dout;
    w_merged = ram_dout;
    case (r_lane)
      2'b00:   w_byte = ram_dout[31:24];
      2'b01:   w_byte = ram_dout[23:16];
      2'b10:   w_byte = ram_dout[15:8];
      default: w_byte = ram_dout[7:0];
    endcase
    if (r_size == 2'b00) begin
      w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      case (r_lane)
        2'b00:   w_merged = {r_wdata[7:0], ram_dout[23:0]};
        2'b01:   w_merged = {ram_dout[31:24], r_wdata[7:0], ram_dout[15:0]};
        2'b10:   w_merged = {ram_dout[31:16], r_wdata[7:0], ram_dout[7:0]};
        default: w_merged = {ram_dout[31:8], r_wdata[7:0]};
      endcase
    end else if (r_size == 2'b01) begin
      w_load   = {{16{r_sext & w_half[15]}}, w_half};
      w_merged = r_lane[1] ? {ram_dout[31:16], r_wdata} : {r_wdata, ram_dout[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_size   <= '0;
      r_sext   <= 1'b0;
      r_lane   <= '0;
      r_wdata  <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          ram_we <= 1'b0;
          if (req) begin
            r_we     <= we;
            r_size   <= size;
            r_sext   <= sign_ext;
            r_lane   <= addr[1:0];
            r_wdata  <= wdata[15:0];
            busy     <= 1'b1;
            ram_addr <= addr[ADDR_W+1:2];
`ifdef MEM_ALIGN_CHECK_EN
            if (w_misalign) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end else
`endif
            if (w_word_store) begin
              ram_din <= wdata;
              ram_we  <= 1'b1;
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: r_state <= S_CAP;
        S_CAP: begin
          if (r_we) begin
            ram_din <= w_merged;
            ram_we  <= 1'b1;
            r_state <= S_WR;
          end else begin
            rdata   <= w_load;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_WR: begin
          ram_we  <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read RAM model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
`ifdef MEM_ALIGN_CHECK_EN
  logic        err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int          lat;
  int          we_cnt;
  logic [11:0] we_addr;
  logic [31:0] we_din;
  logic        err_at_done;

  logic [31:0] mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;

  mem_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef MEM_ALIGN_CHECK_EN
    , .err(err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read data does not change on a write cycle.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    else ram_dout <= mem[ram_addr];
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic access(input logic t_we, input logic [1:0] t_size, input logic t_sext,
                        input logic [31:0] t_addr, input logic [31:0] t_wdata);
    @(negedge clk);
    req = 1'b1; we = t_we; size = t_size; sign_ext = t_sext; addr = t_addr; wdata = t_wdata;
    lat = 0; we_cnt = 0; we_addr = '0; we_din = '0; err_at_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (ram_we) begin
        we_cnt++;
        we_addr = ram_addr;
        we_din  = ram_din;
      end
      if (done) begin
        lat = c;
`ifdef MEM_ALIGN_CHECK_EN
        err_at_done = err;
`endif
        break;
      end
    end
    if (lat == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL access_timeout: no done within 20 cycles for addr %h", t_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ram_we, done, busy} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want 000", {ram_we, done, busy});
    end
    tests_run++;
    if (ram_addr !== 12'h000) begin
      tests_failed++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr);
    end
    tests_run++;
    if (ram_din !== 32'h0 || rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_data: din %h rdata %h want 0", ram_din, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL wstore_lat: got %0d want 2", lat); end
    tests_run++;
    if (we_cnt !== 1 || we_addr !== 12'd4 || we_din !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL wstore_ram: cnt %0d addr %h din %h want 1 004 deadbeef", we_cnt, we_addr, we_din);
    end
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL wload_lat: got %0d want 3", lat); end
    tests_run++;
    if (rdata !== 32'hDEADBEEF || we_cnt !== 0) begin
      tests_failed++; $display("FAIL wload_data: got %h we %0d want deadbeef 0", rdata, we_cnt);
    end
  endtask

  task automatic test_rmw();
    preload(12'd4, 32'h11223344);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL bstore_lat: got %0d want 4", lat); end
    tests_run++;
    if (we_cnt !== 1 || we_addr !== 12'd4 || mem[4] !== 32'h11AA3344) begin
      tests_failed++; $display("FAIL bstore_mem: cnt %0d addr %h mem %h want 1 004 11aa3344", we_cnt, we_addr, mem[4]);
    end
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFEBEEF);
    tests_run++;
    if (mem[4] !== 32'h11AABEEF) begin
      tests_failed++; $display("FAIL hstore_mem: got %h want 11aabeef", mem[4]);
    end
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF01);
    tests_run++;
    if (mem[4] !== 32'h11AABE01) begin
      tests_failed++; $display("FAIL bstore3_mem: got %h want 11aabe01", mem[4]);
    end
    tests_run++;
    if (rdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL store_keeps_rdata: got %h want deadbeef", rdata);
    end
  endtask

  task automatic test_sign();
    preload(12'd4, 32'h80FF7F01);
    access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    tests_run++;
    if (rdata !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_sx_0: got %h want ffffff80", rdata); end
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    tests_run++;
    if (rdata !== 32'h00007F01) begin tests_failed++; $display("FAIL lh_zx_2: got %h want 00007f01", rdata); end
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    tests_run++;
    if (rdata !== 32'h00000001) begin tests_failed++; $display("FAIL lb_sx_3: got %h want 00000001", rdata); end
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    tests_run++;
    if (rdata !== 32'h000000FF) begin tests_failed++; $display("FAIL lb_zx_1: got %h want 000000ff", rdata); end
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    tests_run++;
    if (rdata !== 32'hFFFF80FF) begin tests_failed++; $display("FAIL lh_sx_0: got %h want ffff80ff", rdata); end
    access(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    tests_run++;
    if (rdata !== 32'h0000007F) begin tests_failed++; $display("FAIL lb_sx_2: got %h want 0000007f", rdata); end
    access(1'b0, 2'b11, 1'b1, 32'h10, 32'h0);
    tests_run++;
    if (rdata !== 32'h80FF7F01) begin tests_failed++; $display("FAIL lw_size3: got %h want 80ff7f01", rdata); end
  endtask

  task automatic test_wrap();
    access(1'b1, 2'b10, 1'b0, 32'h4000, 32'h0BADF00D);
    tests_run++;
    if (we_addr !== 12'd0 || mem[0] !== 32'h0BADF00D) begin
      tests_failed++; $display("FAIL wrap_4000: addr %h mem %h want 000 0badf00d", we_addr, mem[0]);
    end
    access(1'b1, 2'b10, 1'b0, 32'hFFFF_3FFC, 32'h12345678);
    tests_run++;
    if (we_addr !== 12'hFFF || mem[4095] !== 32'h12345678) begin
      tests_failed++; $display("FAIL wrap_top: addr %h mem %h want fff 12345678", we_addr, mem[4095]);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    int dcnt;
    preload(12'd8, 32'h5555AAAA);
    preload(12'd4, 32'hA5A5_0F0F);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
    dcnt = 0; d1 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin dcnt++; if (d1 == 0) d1 = c; end
      if (c == 1) begin we = 1'b1; addr = 32'h20; wdata = 32'h12345678; end
      if (c == 3) begin req = 1'b0; we = 1'b0; addr = 32'h10; end
    end
    tests_run++;
    if (dcnt !== 1 || d1 !== 3) begin
      tests_failed++; $display("FAIL busy_ignore_done: count %0d at %0d want 1 at 3", dcnt, d1);
    end
    tests_run++;
    if (mem[8] !== 32'h5555AAAA || rdata !== 32'hA5A50F0F) begin
      tests_failed++; $display("FAIL busy_ignore_data: mem %h rdata %h want 5555aaaa a5a50f0f", mem[8], rdata);
    end
    preload(12'd4, 32'h0000_1234);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin if (d1 == 0) d1 = c; else d2 = c; end
      if (c == 4) begin
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
      end
      if (c == 5) begin
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_reaccept_busy: got %b want 1", busy); end
        req = 1'b0;
      end
    end
    tests_run++;
    if (d1 !== 3 || d2 !== 7) begin
      tests_failed++; $display("FAIL b2b_done_cycles: got %0d,%0d want 3,7", d1, d2);
    end
  endtask

  task automatic test_reset_mid_rmw();
    preload(12'd4, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h55;
    repeat (3) begin
      @(negedge clk);
      req = 1'b0;
    end
    tests_run++;
    if (ram_we !== 1'b1 || ram_din !== 32'h11225544) begin
      tests_failed++; $display("FAIL rst_wr_phase: we %b din %h want 1 11225544", ram_we, ram_din);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ram_we, done, busy} !== 3'b000 || ram_addr !== 12'h0 || ram_din !== 32'h0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_async: we/done/busy %b addr %h din %h rdata %h want 000 0 0 0",
               {ram_we, done, busy}, ram_addr, ram_din, rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (mem[4] !== 32'h11223344 && mem[4] !== 32'h11225544) begin
      tests_failed++; $display("FAIL rst_ram_word: got %h want 11223344 or 11225544", mem[4]);
    end
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    tests_run++;
    if (rdata !== 32'h00000022 || lat !== 3) begin
      tests_failed++; $display("FAIL rst_recover: rdata %h lat %0d want 00000022 3", rdata, lat);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    preload(12'd4, 32'hCAFEF00D);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests_run++;
    if (err_at_done !== 1'b0 || rdata !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL align_ok: err %b rdata %h want 0 cafef00d", err_at_done, rdata);
    end
    access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    tests_run++;
    if (lat !== 1 || err_at_done !== 1'b1 || we_cnt !== 0 || rdata !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL align_lw: lat %0d err %b we %0d rdata %h want 1 1 0 cafef00d", lat, err_at_done, we_cnt, rdata);
    end
    access(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
    tests_run++;
    if (lat !== 1 || err_at_done !== 1'b1 || we_cnt !== 0 || mem[4] !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL align_sh: lat %0d err %b we %0d mem %h want 1 1 0 cafef00d", lat, err_at_done, we_cnt, mem[4]);
    end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL align_err_clear: got %b want 0", err); end
  endtask
`else
  task automatic test_truncate();
    access(1'b1, 2'b10, 1'b0, 32'h13, 32'h01020304);
    tests_run++;
    if (we_addr !== 12'd4 || mem[4] !== 32'h01020304) begin
      tests_failed++; $display("FAIL trunc_sw: addr %h mem %h want 004 01020304", we_addr, mem[4]);
    end
    access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    tests_run++;
    if (rdata !== 32'h00000304) begin
      tests_failed++; $display("FAIL trunc_lh: got %h want 00000304", rdata);
    end
  endtask
`endif

  initial begin
    req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    test_reset();
    test_word_store_load();
    test_rmw();
    test_sign();
    test_wrap();
    test_back_to_back();
    test_reset_mid_rmw();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`else
    test_truncate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
